// File: rtl/tod_pkg.sv
// Shared constants and types for the time-of-day counter.
package tod_pkg;

  localparam int unsigned HOURS_PER_DAY = 24;
  localparam int unsigned MIN_PER_HOUR  = 60;
  localparam int unsigned SEC_PER_MIN   = 60;
  localparam int unsigned H_W           = 5;
  localparam int unsigned MS_W          = 6;

  typedef struct packed {
    logic [H_W-1:0]  hours;
    logic [MS_W-1:0] minutes;
    logic [MS_W-1:0] seconds;
  } tod_t;

endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter with enable, synchronous clear, saturating load and a wrap flag.
module mod_counter
  import tod_pkg::*;
#(
  parameter int unsigned N = 60,
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] q,
  output logic         wrap
);

  localparam logic [W-1:0] MaxVal = W'(N - 1);

  logic [W-1:0] cnt_d, cnt_q;
  logic         at_max;

  assign at_max = (cnt_q == MaxVal);
  // wrap only reports a real increment past the top, not a load or clear
  assign wrap   = en && at_max && !ld && !clr;
  assign q      = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (ld) begin
      cnt_d = (ld_val > MaxVal) ? MaxVal : ld_val;
    end else if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_max ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sync_tod_clock.sv
// Single-clock time-of-day counter: prescaler, h/m/s enable chain, PPS discipline,
// handshake time load and 12h/24h hour remap.
module sync_tod_clock
  import tod_pkg::*;
#(
  parameter int unsigned  DIV    = 100,
  parameter bit           PPS_EN = 1'b1,
  localparam int unsigned SW     = $clog2(DIV)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pps,
  input  logic            mode12,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [H_W-1:0]  load_hours,
  input  logic [MS_W-1:0] load_minutes,
  input  logic [MS_W-1:0] load_seconds,
  output logic [H_W-1:0]  hours,
  output logic            pm,
  output logic [MS_W-1:0] minutes,
  output logic [MS_W-1:0] seconds,
  output logic [SW-1:0]   subsec,
  output logic            s_tick,
  output logic            m_tick,
  output logic            h_tick,
  output logic            d_tick,
  output logic            pps_err
);

  localparam logic [SW-1:0] SubMax  = SW'(DIV - 1);
  localparam logic [SW-1:0] SubHalf = SW'(DIV / 2);

  tod_t       now;
  logic [2:0] pps_d, pps_q;
  logic [3:0] tick_d, tick_q;
  logic       pps_err_d, pps_err_q;
  logic       load_ready_d, load_ready_q;
  logic       accept, pps_edge, pps_act;
  logic       sub_wrap, sec_en, sec_wrap, min_wrap, hour_wrap;

  // pps_q[1:0] is the synchroniser, pps_q[2] the previous synchronised level
  assign accept   = load_valid && load_ready_q;
  assign pps_edge = PPS_EN && pps_q[1] && !pps_q[2];
  assign pps_act  = pps_edge && !accept;
  // a late PPS edge stands in for the natural wrap, so a coincident wrap counts once
  assign sec_en   = pps_act ? (subsec >= SubHalf) : sub_wrap;

  mod_counter #(.N(DIV), .W(SW)) u_sub (
    .clk    (clk),
    .rst    (rst),
    .en     (1'b1),
    .clr    (pps_act),
    .ld     (accept),
    .ld_val ('0),
    .q      (subsec),
    .wrap   (sub_wrap)
  );

  mod_counter #(.N(SEC_PER_MIN), .W(MS_W)) u_sec (
    .clk    (clk),
    .rst    (rst),
    .en     (sec_en),
    .clr    (1'b0),
    .ld     (accept),
    .ld_val (load_seconds),
    .q      (now.seconds),
    .wrap   (sec_wrap)
  );

  mod_counter #(.N(MIN_PER_HOUR), .W(MS_W)) u_min (
    .clk    (clk),
    .rst    (rst),
    .en     (sec_wrap),
    .clr    (1'b0),
    .ld     (accept),
    .ld_val (load_minutes),
    .q      (now.minutes),
    .wrap   (min_wrap)
  );

  mod_counter #(.N(HOURS_PER_DAY), .W(H_W)) u_hour (
    .clk    (clk),
    .rst    (rst),
    .en     (min_wrap),
    .clr    (1'b0),
    .ld     (accept),
    .ld_val (load_hours),
    .q      (now.hours),
    .wrap   (hour_wrap)
  );

  always_comb begin
    pps_d        = {pps_q[1:0], pps};
    tick_d       = {hour_wrap, min_wrap, sec_wrap, sec_en};
    load_ready_d = !accept;
    pps_err_d    = pps_err_q;
    if (accept) begin
      pps_err_d = 1'b0;
    end else if (pps_act && (subsec != '0) && (subsec != SubMax)) begin
      pps_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pps_q        <= '0;
      tick_q       <= '0;
      pps_err_q    <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      pps_q        <= pps_d;
      tick_q       <= tick_d;
      pps_err_q    <= pps_err_d;
      load_ready_q <= load_ready_d;
    end
  end

  always_comb begin
    hours = now.hours;
    if (mode12) begin
      if (now.hours == '0) begin
        hours = H_W'(12);
      end else if (now.hours > H_W'(12)) begin
        hours = now.hours - H_W'(12);
      end
    end
  end

  assign pm         = (now.hours >= H_W'(12));
  assign minutes    = now.minutes;
  assign seconds    = now.seconds;
  assign {d_tick, h_tick, m_tick, s_tick} = tick_q;
  assign pps_err    = pps_err_q;
  assign load_ready = load_ready_q;

endmodule
